// File: rtl/pe_pkg.sv
// pe_pkg: shared state encoding, mode codes and sizing helper for the MAC PE
package pe_pkg;
  typedef enum logic [2:0] {IDLE, CALC, QUANT, RESULT, DRAIN} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int min_acc_len(input int in_len);
    return 2 * in_len;
  endfunction
endpackage

// File: rtl/pe_quant_sat.sv
// pe_quant_sat: arithmetic right shift of the accumulator with optional clip to the output width
module pe_quant_sat #(
  parameter int ACC_LEN = 40,
  parameter int OUT_LEN = 16,
  parameter int FRAC = 8,
  parameter bit SAT = 1'b1
) (
  input  logic signed [ACC_LEN-1:0] acc,
  output logic [OUT_LEN-1:0]        q,
  output logic                      clipped
);
  localparam logic signed [ACC_LEN-1:0] QMAX = {{(ACC_LEN-OUT_LEN+1){1'b0}}, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] QMIN = ~QMAX;
  logic signed [ACC_LEN-1:0] s;
  logic hi, lo;
  always_comb begin
    s = acc >>> FRAC;
    hi = s > QMAX;
    lo = s < QMIN;
    clipped = SAT && (hi || lo);
    q = !clipped ? s[OUT_LEN-1:0] : hi ? {1'b0, {(OUT_LEN-1){1'b1}}} : {1'b1, {(OUT_LEN-1){1'b0}}};
  end
endmodule

// File: rtl/pe_mac_sat.sv
// pe_mac_sat: systolic MAC processing element with add/sub accumulate, saturating quantiser and drain chain
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int IN_LEN = 16,
  parameter int ACC_LEN = 40,
  parameter int OUT_LEN = 16,
  parameter int FRAC = 8,
  parameter bit SAT = 1'b1
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     cal_en,
  input  logic                     cal_done,
  input  logic                     mode,
  input  logic signed [IN_LEN-1:0] westin,
  input  logic signed [IN_LEN-1:0] northin,
  input  logic                     shift,
  input  logic                     din_val,
  input  logic [OUT_LEN-1:0]       din,
  output logic                     n_cal_en,
  output logic                     n_cal_done,
  output logic                     n_mode,
  output logic signed [IN_LEN-1:0] eastout,
  output logic signed [IN_LEN-1:0] southout,
  output logic                     dout_val,
  output logic [OUT_LEN-1:0]       dout,
  output logic                     sat_flag,
  output logic                     err,
  output logic                     busy
);
  localparam int PW = min_acc_len(IN_LEN);
  state_t state;
  logic mode_q, sub, clipped;
  logic signed [PW-1:0] prod;
  logic signed [ACC_LEN-1:0] pext, term, acc;
  logic [OUT_LEN-1:0] q;
  always_comb begin
    prod = PW'(westin) * PW'(northin);
    pext = ACC_LEN'(prod);
    sub = state == IDLE ? mode == MODE_SUB : mode_q == MODE_SUB;
    term = sub ? -pext : pext;
    busy = state != IDLE;
  end
  pe_quant_sat #(.ACC_LEN(ACC_LEN), .OUT_LEN(OUT_LEN), .FRAC(FRAC), .SAT(SAT)) u_quant (
    .acc(acc),
    .q(q),
    .clipped(clipped)
  );
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      acc <= '0;
      mode_q <= 1'b0;
      n_cal_en <= 1'b0;
      n_cal_done <= 1'b0;
      n_mode <= 1'b0;
      eastout <= '0;
      southout <= '0;
      dout_val <= 1'b0;
      dout <= '0;
      sat_flag <= 1'b0;
      err <= 1'b0;
    end else begin
      n_cal_en <= cal_en;
      n_cal_done <= cal_done;
      n_mode <= mode;
      if (cal_en) begin
        eastout <= westin;
        southout <= northin;
      end
      err <= err | (cal_en && state inside {QUANT, RESULT, DRAIN});
      case (state)
        IDLE: if (cal_en) begin
          acc <= term;
          mode_q <= mode;
          sat_flag <= 1'b0;
          state <= cal_done ? QUANT : CALC;
        end
        CALC: begin
          if (cal_en) acc <= acc + term;
          if (cal_done) state <= QUANT;
        end
        QUANT: begin
          dout <= q;
          dout_val <= 1'b1;
          sat_flag <= clipped;
          state <= RESULT;
        end
        RESULT: if (shift) begin
          dout <= din;
          dout_val <= din_val;
          state <= DRAIN;
        end
        DRAIN: if (shift) begin
          dout <= din;
          dout_val <= din_val;
          if (!din_val) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_mac_sat.sv
// tb_pe_mac_sat: randomized and directed checks of a 3-PE drain column plus a wrapping (SAT=0) twin
module tb_pe_mac_sat;
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic shift = 1'b0;
  logic cal_en [3];
  logic cal_done [3];
  logic mode [3];
  logic signed [15:0] w [3];
  logic signed [15:0] n [3];
  logic [15:0] cd [4];
  logic cv [4];
  logic n_en [3];
  logic n_done [3];
  logic n_md [3];
  logic signed [15:0] east [3];
  logic signed [15:0] south [3];
  logic sat [3];
  logic err [3];
  logic busy [3];
  logic ns_n_en, ns_n_done, ns_n_md, ns_val, ns_sat, ns_err, ns_busy;
  logic signed [15:0] ns_east, ns_south;
  logic [15:0] ns_dout;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign cd[0] = '0;
  assign cv[0] = 1'b0;

  for (genvar k = 0; k < 3; k++) begin : g_pe
    pe_mac_sat u (
      .clk(clk), .sys_rst(sys_rst), .cal_en(cal_en[k]), .cal_done(cal_done[k]), .mode(mode[k]),
      .westin(w[k]), .northin(n[k]), .shift(shift), .din_val(cv[k]), .din(cd[k]),
      .n_cal_en(n_en[k]), .n_cal_done(n_done[k]), .n_mode(n_md[k]), .eastout(east[k]),
      .southout(south[k]), .dout_val(cv[k+1]), .dout(cd[k+1]), .sat_flag(sat[k]),
      .err(err[k]), .busy(busy[k])
    );
  end

  pe_mac_sat #(.SAT(1'b0)) u_ns (
    .clk(clk), .sys_rst(sys_rst), .cal_en(cal_en[2]), .cal_done(cal_done[2]), .mode(mode[2]),
    .westin(w[2]), .northin(n[2]), .shift(shift), .din_val(1'b0), .din(16'h0000),
    .n_cal_en(ns_n_en), .n_cal_done(ns_n_done), .n_mode(ns_n_md), .eastout(ns_east),
    .southout(ns_south), .dout_val(ns_val), .dout(ns_dout), .sat_flag(ns_sat),
    .err(ns_err), .busy(ns_busy)
  );

  function automatic logic [15:0] ref_q(input longint acc, input bit sat_en, output bit clip);
    longint a, q;
    a = (acc <<< 24) >>> 24;
    q = a >>> 8;
    clip = sat_en && (q > 32767 || q < -32768);
    return clip ? (q > 0 ? 16'h7fff : 16'h8000) : q[15:0];
  endfunction

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 16'h7fff : r == 1 ? 16'h8000 : 16'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    for (int k = 0; k < 3; k++) begin
      cal_en[k] = 1'b0;
      cal_done[k] = 1'b0;
      mode[k] = 1'b0;
      w[k] = '0;
      n[k] = '0;
    end
    shift = 1'b0;
  endtask

  task automatic do_reset();
    clear();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sys_rst = 1'b1;
      shift = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        cal_en[k] = 1'($urandom);
        cal_done[k] = 1'($urandom);
        mode[k] = 1'($urandom);
        w[k] = 16'($urandom);
        n[k] = 16'($urandom);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({cv[k+1], cd[k+1], east[k], south[k], n_en[k], n_done[k], n_md[k], sat[k], err[k], busy[k]} !== 41'd0)
        $display("FAIL reset pe%0d: outputs %h required 0", k,
          {cv[k+1], cd[k+1], east[k], south[k], n_en[k], n_done[k], n_md[k], sat[k], err[k], busy[k]});
      else passes++;
    end
    checks++;
    if ({ns_val, ns_dout, ns_east, ns_south, ns_n_en, ns_n_done, ns_n_md, ns_sat, ns_err, ns_busy} !== 41'd0)
      $display("FAIL reset ns: outputs %h required 0",
        {ns_val, ns_dout, ns_east, ns_south, ns_n_en, ns_n_done, ns_n_md, ns_sat, ns_err, ns_busy});
    else passes++;
    clear();
    sys_rst = 1'b0;
  endtask

  task automatic test_mac();
    logic [15:0] ws [4];
    ws = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[2] = ws[i];
      n[2] = 16'h0100;
      cal_en[2] = 1'b1;
      cal_done[2] = (i == 3);
      step();
      checks++;
      if (east[2] !== ws[i] || south[2] !== 16'h0100)
        $display("FAIL mac_fwd beat%0d: east %h south %h required %h 0100", i, east[2], south[2], ws[i]);
      else passes++;
      checks++;
      if (n_en[2] !== 1'b1 || n_done[2] !== (i == 3))
        $display("FAIL mac_nctl beat%0d: n_cal_en %b n_cal_done %b required 1 %b", i, n_en[2], n_done[2], i == 3);
      else passes++;
    end
    checks++;
    if (cv[3] !== 1'b0) $display("FAIL mac_early_val: dout_val %b required 0", cv[3]);
    else passes++;
    clear();
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'h0A00) $display("FAIL mac_result: val %b dout %h required 1 0a00", cv[3], cd[3]);
    else passes++;
    checks++;
    if (east[2] !== 16'h0400 || n_en[2] !== 1'b0 || busy[2] !== 1'b1)
      $display("FAIL mac_hold: east %h n_cal_en %b busy %b required 0400 0 1", east[2], n_en[2], busy[2]);
    else passes++;
  endtask

  task automatic test_sub_single();
    do_reset();
    w[2] = 16'h0100;
    n[2] = 16'h0300;
    mode[2] = 1'b1;
    cal_en[2] = 1'b1;
    cal_done[2] = 1'b1;
    step();
    clear();
    checks++;
    if (cv[3] !== 1'b0 || busy[2] !== 1'b1) $display("FAIL sub_early: val %b busy %b required 0 1", cv[3], busy[2]);
    else passes++;
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'hFD00 || ns_dout !== 16'hFD00)
      $display("FAIL sub_result: val %b dout %h ns %h required 1 fd00 fd00", cv[3], cd[3], ns_dout);
    else passes++;
  endtask

  task automatic test_sat();
    logic [15:0] as [2];
    logic [15:0] e, ens;
    longint acc;
    bit clip, nclip;
    as = '{16'h7fff, 16'h8000};
    for (int p = 0; p < 2; p++) begin
      do_reset();
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        w[2] = as[p];
        n[2] = 16'h7fff;
        cal_en[2] = 1'b1;
        cal_done[2] = (i == 3);
        acc += longint'(w[2]) * longint'(n[2]);
        step();
      end
      clear();
      step();
      e = ref_q(acc, 1'b1, clip);
      ens = ref_q(acc, 1'b0, nclip);
      checks++;
      if (cd[3] !== e || sat[2] !== clip || cd[3] !== (p == 0 ? 16'h7fff : 16'h8000))
        $display("FAIL sat%0d: dout %h flag %b required %h %b", p, cd[3], sat[2], e, clip);
      else passes++;
      checks++;
      if (ns_dout !== ens || ns_sat !== 1'b0)
        $display("FAIL wrap%0d: dout %h flag %b required %h 0", p, ns_dout, ns_sat, ens);
      else passes++;
      shift = 1'b1;
      step();
      step();
      shift = 1'b0;
      checks++;
      if (busy[2] !== 1'b0) $display("FAIL sat_drain%0d: busy %b required 0", p, busy[2]);
      else passes++;
      w[2] = 16'h0100;
      n[2] = 16'h0100;
      cal_en[2] = 1'b1;
      cal_done[2] = 1'b1;
      step();
      clear();
      checks++;
      if (sat[2] !== 1'b0) $display("FAIL sat_clear%0d: flag %b required 0", p, sat[2]);
      else passes++;
    end
  endtask

  task automatic test_drain();
    logic [15:0] r [3];
    logic [15:0] jw;
    r = '{16'h0011, 16'h0022, 16'h0033};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w[k] = r[k];
      n[k] = 16'h0100;
      cal_en[k] = 1'b1;
      cal_done[k] = 1'b1;
    end
    step();
    clear();
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'h0033) $display("FAIL drain_own: val %b dout %h required 1 0033", cv[3], cd[3]);
    else passes++;
    jw = 16'($urandom);
    w[2] = jw;
    cal_en[2] = 1'b1;
    step();
    clear();
    checks++;
    if (err[2] !== 1'b1 || err[1] !== 1'b0 || cd[3] !== 16'h0033 || east[2] !== jw)
      $display("FAIL result_err: err %b/%b dout %h east %h required 1/0 0033 %h", err[2], err[1], cd[3], east[2], jw);
    else passes++;
    shift = 1'b1;
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'h0022) $display("FAIL drain_1: val %b dout %h required 1 0022", cv[3], cd[3]);
    else passes++;
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'h0011) $display("FAIL drain_2: val %b dout %h required 1 0011", cv[3], cd[3]);
    else passes++;
    step();
    step();
    shift = 1'b0;
    checks++;
    if (cv[3] !== 1'b0 || busy[0] !== 1'b0 || busy[1] !== 1'b0 || busy[2] !== 1'b0)
      $display("FAIL drain_end: val %b busy %b%b%b required 0 000", cv[3], busy[0], busy[1], busy[2]);
    else passes++;
    checks++;
    if (err[2] !== 1'b1) $display("FAIL err_sticky: err %b required 1", err[2]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    checks++;
    if (err[2] !== 1'b0) $display("FAIL err_reset: err %b required 0", err[2]);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      w[2] = pick();
      n[2] = pick();
      cal_en[2] = 1'b1;
      step();
    end
    clear();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    checks++;
    if (busy[2] !== 1'b0) $display("FAIL midrst_busy: busy %b required 0", busy[2]);
    else passes++;
    w[2] = 16'h0200;
    n[2] = 16'h0100;
    cal_en[2] = 1'b1;
    cal_done[2] = 1'b1;
    step();
    clear();
    step();
    checks++;
    if (cv[3] !== 1'b1 || cd[3] !== 16'h0200) $display("FAIL midrst_result: val %b dout %h required 1 0200", cv[3], cd[3]);
    else passes++;
  endtask

  task automatic test_random();
    longint acc;
    logic [15:0] e, ens;
    bit clip, nclip, m, sep;
    int len;
    do_reset();
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(1, 6);
      m = 1'($urandom);
      sep = 1'($urandom);
      acc = 0;
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) begin
          cal_en[2] = 1'b0;
          cal_done[2] = 1'b0;
          w[2] = 16'($urandom);
          n[2] = 16'($urandom);
          mode[2] = 1'($urandom);
          step();
        end
        w[2] = pick();
        n[2] = pick();
        mode[2] = i == 0 ? m : 1'($urandom);
        cal_en[2] = 1'b1;
        cal_done[2] = (i == len - 1) && !sep;
        acc += (m ? -1 : 1) * (longint'(w[2]) * longint'(n[2]));
        step();
      end
      if (sep) begin
        cal_en[2] = 1'b0;
        cal_done[2] = 1'b1;
        step();
      end
      clear();
      step();
      e = ref_q(acc, 1'b1, clip);
      ens = ref_q(acc, 1'b0, nclip);
      checks++;
      if (cv[3] !== 1'b1 || cd[3] !== e || sat[2] !== clip)
        $display("FAIL rand%0d sat: val %b dout %h flag %b required 1 %h %b", j, cv[3], cd[3], sat[2], e, clip);
      else passes++;
      checks++;
      if (ns_val !== 1'b1 || ns_dout !== ens || ns_sat !== 1'b0)
        $display("FAIL rand%0d wrap: val %b dout %h flag %b required 1 %h 0", j, ns_val, ns_dout, ns_sat, ens);
      else passes++;
      shift = 1'b1;
      step();
      step();
      shift = 1'b0;
    end
    checks++;
    if (busy[2] !== 1'b0 || ns_busy !== 1'b0 || err[2] !== 1'b0)
      $display("FAIL rand_end: busy %b ns %b err %b required 0 0 0", busy[2], ns_busy, err[2]);
    else passes++;
  endtask

  initial begin
    clear();
    test_reset();
    test_mac();
    test_sub_single();
    test_sat();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
